// File: rtl/decrypt_if.sv
// AXI4-Stream bundle used on both sides of the decrypt block.
// master drives the payload and valid, slave drives ready.
interface decrypt_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned USER_WIDTH = 128
);
  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tkeep, output tuser, output tvalid, output tlast,
                  input  tready);
  modport slave  (input  tdata, input  tkeep, input  tuser, input  tvalid, input  tlast,
                  output tready);
endinterface

// File: rtl/decrypt.sv
// Receive-side payload XOR decryptor: word 0 and the low header bits of word 1 pass,
// the rest is XORed with the per-packet key. Registered output with one skid entry.
// Define DECRYPT_STATS_EN to build the packet/runt counters; otherwise they read 0.
module decrypt #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned HDR_BYPASS_BITS      = 16
) (
  input  logic        axis_aclk,
  input  logic        axis_reset,
  input  logic [31:0] key,
  decrypt_if.slave    s_axis,
  decrypt_if.master   m_axis,
  output logic [31:0] stat_pkt_count,
  output logic [31:0] stat_runt_count
);

  localparam int unsigned DW       = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned KW       = DW / 8;
  localparam int unsigned UW       = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned MKW      = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned KEY_W    = 32;
  localparam int unsigned KEY_REPS = DW / KEY_W;

  typedef enum logic [1:0] {
    WORD0   = 2'd0,
    WORD1   = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  state_t        state_q, state_d;
  logic [KEY_W-1:0] key_q;
  logic [DW-1:0] key_mask;
  beat_t         in_beat, xform_beat;
  beat_t         out_q, skid_q;
  logic          out_valid_q, skid_valid_q;
  logic          accept, drain;

  // Ready comes straight from the skid flag, so m_axis.tready never reaches s_axis.tready.
  assign accept   = s_axis.tvalid & ~skid_valid_q;
  assign drain    = out_valid_q & m_axis.tready;
  assign key_mask = {KEY_REPS{key_q}};

  assign in_beat = '{data: s_axis.tdata, keep: s_axis.tkeep,
                     user: s_axis.tuser, last: s_axis.tlast};

  // Packet position register; key is captured with the first beat of each packet.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q <= WORD0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept && (state_q == WORD0)) begin
        key_q <= key;
      end
    end
  end

  // Next position and the transformed beat for the current position.
  always_comb begin
    state_d    = state_q;
    xform_beat = in_beat;
    case (state_q)
      WORD0: begin
        if (accept && !in_beat.last) state_d = WORD1;
      end
      WORD1: begin
        xform_beat.data = in_beat.data ^
                          {key_mask[DW-1:HDR_BYPASS_BITS], HDR_BYPASS_BITS'(0)};
        if (accept) state_d = in_beat.last ? WORD0 : PAYLOAD;
      end
      PAYLOAD: begin
        xform_beat.data = in_beat.data ^ key_mask;
        if (accept && in_beat.last) state_d = WORD0;
      end
      default: state_d = WORD0;
    endcase
  end

  // Output register plus skid; accept is only possible while the skid entry is empty.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (accept) begin
      if (!out_valid_q || drain) begin
        out_q       <= xform_beat;
        out_valid_q <= 1'b1;
      end else begin
        skid_q       <= xform_beat;
        skid_valid_q <= 1'b1;
      end
    end else if (drain) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign s_axis.tready = ~skid_valid_q;
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = C_M_AXIS_DATA_WIDTH'(out_q.data);
  assign m_axis.tkeep  = MKW'(out_q.keep);
  assign m_axis.tuser  = C_M_AXIS_TUSER_WIDTH'(out_q.user);
  assign m_axis.tlast  = out_q.last;

`ifdef DECRYPT_STATS_EN
  logic [31:0] pkt_q, runt_q;

  // Saturating counters: packets leaving the block, single-beat packets entering it.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      pkt_q  <= '0;
      runt_q <= '0;
    end else begin
      if (drain && out_q.last && (pkt_q != '1)) begin
        pkt_q <= pkt_q + 32'd1;
      end
      if (accept && (state_q == WORD0) && in_beat.last && (runt_q != '1)) begin
        runt_q <= runt_q + 32'd1;
      end
    end
  end

  assign stat_pkt_count  = pkt_q;
  assign stat_runt_count = runt_q;
`else
  assign stat_pkt_count  = '0;
  assign stat_runt_count = '0;
`endif

endmodule

// File: tb/tb_decrypt.sv
// Directed and randomized checks for decrypt: header bypass, key latching, skid backpressure,
// reset recovery, counters and an encrypt/decrypt round trip.
module tb_decrypt;

  localparam int unsigned DW = 256;
  localparam int unsigned UW = 128;
  localparam int unsigned KW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] key;
  logic [31:0] stat_pkt;
  logic [31:0] stat_runt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decrypt_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();
  decrypt_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();

  decrypt dut (
    .axis_aclk      (clk),
    .axis_reset     (rst),
    .key            (key),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .stat_pkt_count (stat_pkt),
    .stat_runt_count(stat_runt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    logic [31:0]   key;
  } tbeat_t;

  tbeat_t in_q[$];
  tbeat_t exp_q[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] fill(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [255:0] meta(input logic last, input logic [KW-1:0] kp,
                                        input logic [UW-1:0] us);
    return 256'({last, kp, us});
  endfunction

  // Encryptor model: beat 0 clear, beat 1 clear in the low 16 bits, rest fully XORed.
  function automatic logic [255:0] enc(input logic [255:0] d, input int idx, input logic [31:0] k);
    logic [255:0] m;
    m = {8{k}};
    if (idx == 0) return d;
    if (idx == 1) return d ^ {m[255:16], 16'h0000};
    return d ^ m;
  endfunction

  // One beat with both sides ready; output must appear right after the accepting edge.
  task automatic beat(input string tag, input logic [255:0] d, input logic last,
                      input logic [255:0] exp);
    logic [KW-1:0] kp;
    logic [UW-1:0] us;
    kp = d[31:0] ^ 32'hA5A5_5A5A;
    us = d[127:0] ^ 128'hC0FFEE;
    s_if.tdata  = d;
    s_if.tkeep  = kp;
    s_if.tuser  = us;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    check({tag, "_rdy"}, 256'(s_if.tready), 256'(1));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_vld"}, 256'(m_if.tvalid), 256'(1));
    check({tag, "_data"}, m_if.tdata, exp);
    check({tag, "_meta"}, meta(m_if.tlast, m_if.tkeep, m_if.tuser), meta(last, kp, us));
    s_if.tvalid = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle-driven stream of in_q against exp_q; bp selects the fixed backpressure pattern.
  task automatic run_stream(input string tag, input bit bp, input int max_cycles);
    int   idx  = 0;
    int   cyc  = 0;
    bit   pend = 1'b0;
    bit   done = 1'b0;
    logic tr;
    while (!done && cyc < max_cycles) begin
      @(negedge clk);
      if (pend) idx++;
      tr = bp ? !(cyc >= 2 && cyc <= 4) : ($urandom_range(0, 3) != 0);
      m_if.tready = tr;
      if (bp && (cyc == 3 || cyc == 4)) begin
        check("bp_rdy_low", 256'(s_if.tready), 256'(0));
        if (exp_q.size() != 0) check("bp_hold", m_if.tdata, exp_q[0].data);
      end
      if (bp && cyc == 6) check("bp_rdy_high", 256'(s_if.tready), 256'(1));
      if (m_if.tvalid && tr) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra"}, 256'(m_if.tvalid), 256'(0));
        end else begin
          check({tag, "_data"}, m_if.tdata, exp_q[0].data);
          check({tag, "_meta"}, meta(m_if.tlast, m_if.tkeep, m_if.tuser),
                meta(exp_q[0].last, exp_q[0].keep, exp_q[0].user));
          void'(exp_q.pop_front());
        end
      end
      if (idx < in_q.size() && (bp || (s_if.tvalid && !pend) || $urandom_range(0, 4) != 0)) begin
        s_if.tdata  = in_q[idx].data;
        s_if.tkeep  = in_q[idx].keep;
        s_if.tuser  = in_q[idx].user;
        s_if.tlast  = in_q[idx].last;
        key         = in_q[idx].key;
        s_if.tvalid = 1'b1;
      end else begin
        s_if.tvalid = 1'b0;
      end
      pend = s_if.tvalid && s_if.tready;
      cyc++;
      done = (idx == in_q.size()) && !pend && (exp_q.size() == 0);
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    if (!done) check({tag, "_timeout"}, 256'(exp_q.size()), 256'(0));
    in_q.delete();
    exp_q.delete();
  endtask

  task automatic add_packet(input int n, input logic [31:0] k, input bit rnd, input logic [7:0] base);
    tbeat_t b;
    logic [255:0] orig;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        for (int w = 0; w < 8; w++) orig[w*32 +: 32] = $urandom;
        b.keep = $urandom;
        b.user = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        orig   = fill(8'(base + 8'(i)));
        b.keep = 32'hFFFF_FFFF;
        b.user = 128'(i);
      end
      b.last = (i == n - 1);
      b.data = orig;
      exp_q.push_back(b);
      b.data = enc(orig, i, k);
      b.key  = (i == 0) ? k : $urandom;
      in_q.push_back(b);
    end
  endtask

  initial begin
    rst         = 1'b1;
    key         = '0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld", 256'(m_if.tvalid), 256'(0));
    check("rst_data", m_if.tdata, 256'(0));
    check("rst_meta", meta(m_if.tlast, m_if.tkeep, m_if.tuser), 256'(0));
    check("rst_rdy", 256'(s_if.tready), 256'(1));
    check("rst_stats", 256'({stat_pkt, stat_runt}), 256'(0));
    rst = 1'b0;

    key = 32'hFFFF_FFFF;
    beat("basic0", fill(8'h11), 1'b0, fill(8'h11));
    beat("basic1", fill(8'hAA), 1'b0, {{30{8'h55}}, 16'hAAAA});
    beat("basic2", fill(8'h00), 1'b1, fill(8'hFF));

    key = 32'hFFFF_FFFF;
    beat("kc0", fill(8'h00), 1'b0, fill(8'h00));
    key = 32'h0000_0000;
    beat("kc1", fill(8'h00), 1'b0, {{30{8'hFF}}, 16'h0000});
    beat("kc2", fill(8'h00), 1'b1, fill(8'hFF));
    beat("kc_next0", fill(8'h3C), 1'b0, fill(8'h3C));
    beat("kc_next1", fill(8'hC3), 1'b1, fill(8'hC3));

    reset_dut();
    key = 32'hFFFF_FFFF;
    beat("runt", fill(8'h77), 1'b1, fill(8'h77));
    beat("pkt2_0", fill(8'h66), 1'b0, fill(8'h66));
    beat("pkt2_1", fill(8'h66), 1'b1, {{30{8'h99}}, 16'h6666});
    @(negedge clk);
    check("drained_vld", 256'(m_if.tvalid), 256'(0));
`ifdef DECRYPT_STATS_EN
    check("stat_runt", 256'(stat_runt), 256'(1));
    check("stat_pkt", 256'(stat_pkt), 256'(2));
`else
    check("stat_runt", 256'(stat_runt), 256'(0));
    check("stat_pkt", 256'(stat_pkt), 256'(0));
`endif

    // Reset with two beats buffered in the middle of a packet.
    key         = 32'h0F0F_0F0F;
    m_if.tready = 1'b0;
    s_if.tdata  = fill(8'h01);
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_if.tdata = fill(8'h02);
    @(posedge clk);
    @(negedge clk);
    check("mid_full_rdy", 256'(s_if.tready), 256'(0));
    check("mid_out_vld", 256'(m_if.tvalid), 256'(1));
    s_if.tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_vld", 256'(m_if.tvalid), 256'(0));
    check("mid_rst_rdy", 256'(s_if.tready), 256'(1));
    m_if.tready = 1'b1;
    key = 32'hFFFF_FFFF;
    beat("post_rst0", fill(8'h5A), 1'b0, fill(8'h5A));
    beat("post_rst1", fill(8'h5A), 1'b1, {{30{8'hA5}}, 16'h5A5A});

    add_packet(6, 32'h1234_5678, 1'b0, 8'h10);
    run_stream("bp", 1'b1, 200);

    for (int p = 0; p < 200; p++) add_packet($urandom_range(1, 12), $urandom, 1'b1, 8'h00);
    run_stream("rt", 1'b0, 30000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/decrypt.md
# decrypt

AXI4-Stream receive-side counterpart of the payload XOR encryptor in the crypto_switch datapath: restores original packet contents by re-applying the 32-bit key. Placed downstream of the encrypting pipeline, before the output queues. Passes the first 256-bit word and the low 16 bits of the second word unchanged, and XORs everything after that. Adds a registered output stage with a skid buffer, so it closes timing at full line rate.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, master tdata width (block is defined for 256 only)
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width (must equal master)
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width
- HDR_BYPASS_BITS, 16, low bits of word 1 left unmodified

Ports:
- axis_aclk  in  1  single clock for all logic
- axis_reset  in  1  synchronous, active-high reset
- key  in  32  decryption key, sampled per packet
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/128/1/1  input stream
- s_axis_tready  out  1  input ready
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  256/32/128/1/1  output stream, registered
- m_axis_tready  in  1  downstream ready
- stat_pkt_count  out  32  packets forwarded (tlast beats emitted)
- stat_runt_count  out  32  single-beat packets seen

## Operation
- Beat accepted = s_axis_tvalid & s_axis_tready. The state advances only on an accepted beat.
- States:
  - WORD0: accepted beat passes unmodified. key is latched into key_q on the same edge. tlast=1 keeps the state in WORD0 and increments stat_runt_count; otherwise the state moves to WORD1.
  - WORD1: data[255:16] ^= {8{key_q}}[255:16]; data[15:0] is unmodified. tlast=1 moves to WORD0; otherwise to PAYLOAD.
  - PAYLOAD: full 256-bit XOR with {8{key_q}}. tlast=1 moves to WORD0.
- The XOR covers all bytes regardless of tkeep. tkeep, tuser and tlast are forwarded unchanged.
- Changes on key mid-packet have no effect until the next WORD0 beat.
- Output stage: out register plus one skid register.
  - An accepted beat loads the out register if it is empty or draining this cycle (m_axis_tvalid & m_axis_tready); otherwise it loads the skid register.
  - On a drain with the skid register full, skid moves to out.
  - s_axis_tready = !skid_valid, taken from a register with no combinational path from m_axis_tready.
  - Beat order is preserved. No beat is dropped or duplicated.
- stat_pkt_count increments when a beat with tlast=1 drains from the out register.
- Both counters saturate at 0xFFFFFFFF.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on m_axis_* after edge N.
- Throughput is 1 beat/cycle while m_axis_tready=1.
- Under backpressure:
  - The block holds 2 beats.
  - s_axis_tready drops in the cycle after the second beat is buffered.
  - s_axis_tready rises in the cycle after the skid register empties.
- m_axis_* is held stable while m_axis_tvalid=1 and m_axis_tready=0.
- Simultaneous accept and drain with the skid register empty: the out register reloads and there is no bubble.
- Reset values: m_axis_tvalid=0, tdata/tkeep/tuser/tlast=0, s_axis_tready=1 (from the first cycle after reset), state=WORD0, key_q=0, counters=0.
- Reset mid-packet:
  - Buffered beats are discarded.
  - The first beat accepted after reset is treated as WORD0.

## Configuration
- DECRYPT_STATS_EN defined: stat_pkt_count and stat_runt_count are implemented as specified above.
- DECRYPT_STATS_EN undefined: counter logic is omitted, both stat outputs are tied to 0, and datapath behaviour is identical.

## Test plan
- Basic packet: key=0xFFFFFFFF; 3 beats, all bytes 0x11, then 0xAA, then 0x00 (tlast on the third) -> outputs are all 0x11, then {240'h55..55,16'hAAAA}, then all 0xFF. Each appears 1 cycle after acceptance.
- Backpressure: stream 6 beats; hold m_axis_tready=0 for cycles 2–4 -> s_axis_tready=0 after 2 beats are buffered. Output order and data match expected, with no loss or duplicates.
- Key change mid-packet: key=0xFFFFFFFF at WORD0, changed to 0 at beat 2 -> beat 2 is still XORed with 0xFFFFFFFF. The next packet with key=0 passes through unchanged.
- Runt packet: single beat with tlast=1, then a 2-beat packet -> both first beats are unmodified. With the macro defined, stat_runt_count=1 and stat_pkt_count=2; with it undefined, both read 0.
- Round trip: 200 random packets of 1–12 beats through the encryptor and then this block, with random tready -> output equals the original stimulus bit-exact.
- Reset mid-packet: assert axis_reset for 1 cycle after beat 2 of 5 -> m_axis_tvalid=0 the next cycle. The next accepted beat passes unmodified as WORD0.
